// File: rtl/asicle_pkg.sv
// Shared types and sizing for the guess-row colour scorer.
// Colour codes match the encoding packed into the colors bus.
package asicle_pkg;

  localparam int WORD_LEN  = 5;
  localparam int NUM_WORDS = 7;
  localparam int MAT_W     = WORD_LEN * WORD_LEN;
  localparam int IDX_W     = 3;
  localparam int CNT_W     = 3;
  localparam int COLORS_W  = 2 * WORD_LEN;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    GREY   = 2'd1,
    YELLOW = 2'd2,
    GREEN  = 2'd3
  } color_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SCORE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Diagonal of the cross matrix: guess[k] == solution[k].
  function automatic logic [WORD_LEN-1:0] diag(input logic [MAT_W-1:0] m);
    logic [WORD_LEN-1:0] d;
    d = '0;
    for (int k = 0; k < WORD_LEN; k++) begin
      d[k] = m[WORD_LEN*k + k];
    end
    return d;
  endfunction

endpackage

// File: rtl/letter_color.sv
// Colour of one guess letter from the captured match matrices.
// Greens are exact; yellows are granted left-to-right against unmatched solution letters.
module letter_color
  import asicle_pkg::*;
(
  input  logic [IDX_W-1:0]    pos,
  input  logic [MAT_W-1:0]    cross_mat,
  input  logic [MAT_W-1:0]    self_mat,
  output color_t              color,
  output logic [WORD_LEN-1:0] green
);

  logic [WORD_LEN-1:0] cross_row;
  logic [WORD_LEN-1:0] self_row;
  logic [WORD_LEN-1:0] earlier;
  logic                green_i;
  logic [CNT_W-1:0]    avail;
  logic [CNT_W-1:0]    prior;

  always_comb begin
    green     = diag(cross_mat);
    cross_row = '0;
    self_row  = '0;
    earlier   = '0;
    green_i   = 1'b0;
    for (int r = 0; r < WORD_LEN; r++) begin
      if (pos == IDX_W'(r)) begin
        cross_row = cross_mat[r*WORD_LEN +: WORD_LEN];
        self_row  = self_mat[r*WORD_LEN +: WORD_LEN];
        green_i   = green[r];
        for (int k = 0; k < r; k++) begin
          earlier[k] = 1'b1;
        end
      end
    end
  end

  // Solution letters still free for yellows, and earlier same-letter guesses already using them.
  always_comb begin
    avail = '0;
    prior = '0;
    for (int j = 0; j < WORD_LEN; j++) begin
      if (cross_row[j] && !green[j]) begin
        avail = avail + CNT_W'(1);
      end
      if (earlier[j] && self_row[j] && !green[j]) begin
        prior = prior + CNT_W'(1);
      end
    end
  end

  always_comb begin
    if (green_i) begin
      color = GREEN;
    end else if (prior < avail) begin
      color = YELLOW;
    end else begin
      color = GREY;
    end
  end

endmodule

// File: rtl/color_scorer.sv
// Scores one game_board row against the solution row, one letter per cycle.
// Result is held on colors/all_green until the colors handshake completes.
//
// state  | meaning
// IDLE   | ready for a request; word_index holds its last value
// SETTLE | board rows settle for the new word_index; matrices captured at exit
// SCORE  | one letter coloured per cycle, pos 0..4
// DONE   | result valid, waiting for colors_ready
module color_scorer
  import asicle_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [IDX_W-1:0]    req_word,
  output logic [IDX_W-1:0]    word_index,
  input  logic [MAT_W-1:0]    cross_match_matrix,
  input  logic [MAT_W-1:0]    self_match_matrix,
  output logic                colors_valid,
  input  logic                colors_ready,
  output logic [COLORS_W-1:0] colors,
  output logic                all_green
);

  state_t              state;
  state_t              state_nx;
  logic [IDX_W-1:0]    pos;
  logic                bad;
  logic [MAT_W-1:0]    cross_q;
  logic [MAT_W-1:0]    self_q;
  color_t              letter_col;
  color_t              write_col;
  logic [WORD_LEN-1:0] green;
  logic                last_pos;
  logic                accept;

  assign last_pos  = (pos == IDX_W'(WORD_LEN - 1));
  assign accept    = req_valid && req_ready;
  assign write_col = bad ? GREY : letter_col;

  letter_color u_letter_color (
    .pos       (pos),
    .cross_mat (cross_q),
    .self_mat  (self_q),
    .color     (letter_col),
    .green     (green)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req_valid) state_nx = SETTLE;
      SETTLE:  state_nx = SCORE;
      SCORE:   if (last_pos) state_nx = DONE;
      DONE:    if (colors_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready    = (state == IDLE);
    colors_valid = (state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_index <= '0;
      colors     <= '0;
      all_green  <= 1'b0;
      pos        <= '0;
      bad        <= 1'b0;
      cross_q    <= '0;
      self_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            word_index <= req_word;
            colors     <= '0;
            all_green  <= 1'b0;
            bad        <= (int'(req_word) >= NUM_WORDS);
          end
        end
        SETTLE: begin
          // Board rows lag word_index by one cycle, so they are valid only now.
          cross_q <= cross_match_matrix;
          self_q  <= self_match_matrix;
          pos     <= '0;
        end
        SCORE: begin
          for (int k = 0; k < WORD_LEN; k++) begin
            if (pos == IDX_W'(k)) begin
              colors[2*k +: 2] <= write_col;
            end
          end
          if (last_pos) begin
            pos       <= '0;
            all_green <= (&green) && !bad;
          end else begin
            pos <= pos + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
